csr_trap_ctrl: RTL and testbench
================================

# csr_trap_ctrl

Trap/return sequencer and CSR write-port arbiter between the writeback stage and the single-write-port CSR file. On an exception flush it performs mepc, mcause and mstatus updates one per cycle, then issues a fetch redirect to mtvec. On an mret flush it restores mstatus and redirects to mepc. In idle it forwards ordinary writeback CSR writes unchanged.

## Interface
- No parameters. CSR addresses and field positions are fixed constants.
- clock  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high
- wb_csr_we_i  in  1  writeback CSR write strobe, already qualified by valid
- wb_csr_addr_i  in  12  writeback CSR address
- wb_csr_wdata_i  in  32  writeback CSR data
- excp_flush_i  in  1  writeback reports an excepting instruction
- mret_flush_i  in  1  writeback reports a committing mret
- excp_mcause_i  in  32  cause code, valid with excp_flush_i
- excp_mepc_i  in  32  PC of the excepting instruction
- mtvec_rd_i  in  32  current mtvec read value
- mepc_rd_i  in  32  current mepc read value
- mstatus_rd_i  in  32  current mstatus read value
- csr_we_o  out  1  CSR file write enable
- csr_addr_o  out  12  CSR file write address
- csr_wdata_o  out  32  CSR file write data
- redirect_valid_o  out  1  one-cycle fetch redirect pulse
- redirect_pc_o  out  32  redirect target
- busy_o  out  1  sequence in progress; frontend holds fetch
- wr_drop_o  out  1  sticky flag: a writeback CSR write was dropped while busy

## Operation
- States: IDLE, T_EPC, T_CAUSE, T_STATUS, M_STATUS, REDIR.
- In IDLE, pass-through is combinational: csr_* = wb_csr_*.
- Event priority in IDLE: excp_flush_i > mret_flush_i > wb_csr_we_i.
- A wb_csr_we_i coinciding with either flush is suppressed. This is not a drop, because the excepting instruction must not commit.
- excp_flush_i in IDLE:
  - Latch mcause and mepc; mepc is latched with bits [1:0] cleared.
  - Sequence: T_EPC writes 0x341 with the latched mepc.
  - T_CAUSE writes 0x342 with the latched cause.
  - T_STATUS writes 0x300 with mstatus_rd_i modified: MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11. All other bits are unchanged.
  - REDIR follows, then IDLE.
- mret_flush_i in IDLE:
  - M_STATUS writes 0x300 with MIE[3]=MPIE[7], MPIE[7]=1, MPP=2'b11.
  - REDIR follows, then IDLE.
- REDIR: redirect_valid_o=1.
  - Trap target: pc={mtvec_rd_i[31:2],2'b00}, sampled in REDIR. Direct and vectored modes both use the base, since these are exceptions only.
  - mret target: pc={mepc_rd_i[31:2],2'b00}, sampled in REDIR.
  - A latched kind bit selects between the two targets.
- mstatus_rd_i is sampled live in T_STATUS and M_STATUS. No other writer exists while busy.
- Events in non-IDLE states:
  - A flush is ignored; the pipeline is already flushed.
  - wb_csr_we_i is dropped and sets wr_drop_o, which is cleared only by reset.
- busy_o=1 in every state except IDLE.

## Timing
- Reset values:
  - State IDLE.
  - csr_we_o=0, redirect_valid_o=0, busy_o=0, wr_drop_o=0.
  - csr_addr_o, csr_wdata_o and redirect_pc_o are 0.
- Trap with excp_flush_i at cycle T:
  - mepc write at T+1, mcause at T+2, mstatus at T+3.
  - Redirect at T+4; IDLE at T+5, where a new flush is accepted.
  - busy_o is high T+1..T+4.
- mret with flush at T: mstatus write at T+1, redirect at T+2, IDLE at T+3.
- Pass-through write has zero latency.
- Exactly one CSR write per cycle, and never during REDIR.
- Reset mid-sequence returns to IDLE next edge. No further writes and no redirect are issued. Partially written CSRs are left as written.

## Structure
- Add to riscv_param.vh:
  - CSR address constants MSTATUS 12'h300, MTVEC 12'h305, MEPC 12'h341, MCAUSE 12'h342.
  - mstatus bit positions MIE=3, MPIE=7, MPP=12:11.
  - State encodings.
- Sub-module mstatus_upd: combinational. Inputs mstatus and a trap/mret select; output is the next mstatus.

## Test plan
- Exception: excp_flush_i, cause 0x2, mepc 0x80000104, mstatus 0x00000008, mtvec 0x80000401 → writes at T+1, T+2, T+3, then redirect 0x80000400 at T+4.
  - T+1: (0x341, 0x80000104).
  - T+2: (0x342, 0x2).
  - T+3: (0x300, 0x00001880).
- mret: mret_flush_i, mstatus 0x00001880, mepc 0x80000108 → (0x300, 0x00001888) at T+1, then redirect 0x80000108 at T+2.
- Pass-through: wb write (0x305, 0x80000000) in IDLE → same-cycle csr_we_o with identical address and data, busy_o=0.
- Collision: excp_flush_i and wb_csr_we_i together → wb write suppressed, wr_drop_o stays 0, trap sequence proceeds. A wb_csr_we_i at T+2 → no write of it, wr_drop_o=1 from T+3.
- Reset at T+2 of a trap → no mstatus write, no redirect, IDLE with all outputs 0. A fresh mret then completes normally.

Source files
------------

// File: rtl/csr_trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_trap_ctrl_pkg
// Description : Shared constants and types for the trap/return sequencer.
//               Holds the CSR addresses, mstatus field positions, the PC
//               alignment mask and the sequencer state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package csr_trap_ctrl_pkg;

    // CSR addresses driven onto the CSR file write port
    localparam logic [11:0] c_CSR_MSTATUS = 12'h300;
    localparam logic [11:0] c_CSR_MTVEC   = 12'h305;
    localparam logic [11:0] c_CSR_MEPC    = 12'h341;
    localparam logic [11:0] c_CSR_MCAUSE  = 12'h342;

    // mstatus field positions
    localparam int c_MIE_BIT  = 3;
    localparam int c_MPIE_BIT = 7;
    localparam int c_MPP_HI   = 12;
    localparam int c_MPP_LO   = 11;

    // Clears the two low bits of a PC (instruction alignment)
    localparam logic [31:0] c_PC_MASK = 32'hFFFF_FFFC;

    // Sequencer states, explicitly encoded
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_T_EPC    = 3'd1,
        ST_T_CAUSE  = 3'd2,
        ST_T_STATUS = 3'd3,
        ST_M_STATUS = 3'd4,
        ST_REDIR    = 3'd5
    } state_e;

    // Kind of sequence in flight; selects both the mstatus rewrite and the
    // redirect target
    typedef enum logic {
        KIND_TRAP = 1'b0,
        KIND_MRET = 1'b1
    } kind_e;

endpackage : csr_trap_ctrl_pkg
`default_nettype wire

// File: rtl/csr_trap_ctrl_mstatus_upd.sv
`default_nettype none
// ============================================================================
// Module      : csr_trap_ctrl_mstatus_upd
// Description : Combinational mstatus rewrite for trap entry and mret.
//               Trap : MPIE=MIE, MIE=0, MPP=M
//               mret : MIE=MPIE, MPIE=1, MPP=M
//               All other bits pass through unchanged.
// Ports       : mstatus_i  current mstatus value
//               kind_i     KIND_TRAP or KIND_MRET
//               mstatus_o  updated mstatus value
// Revision    : 1.0  initial release
// ============================================================================
module csr_trap_ctrl_mstatus_upd
    import csr_trap_ctrl_pkg::*;
(
    input  logic [31:0] mstatus_i,
    input  kind_e       kind_i,
    output logic [31:0] mstatus_o
);

    always_comb begin
        mstatus_o                     = mstatus_i;
        mstatus_o[c_MPP_HI:c_MPP_LO]  = 2'b11;
        if (kind_i == KIND_TRAP) begin
            mstatus_o[c_MPIE_BIT] = mstatus_i[c_MIE_BIT];
            mstatus_o[c_MIE_BIT]  = 1'b0;
        end else begin
            mstatus_o[c_MIE_BIT]  = mstatus_i[c_MPIE_BIT];
            mstatus_o[c_MPIE_BIT] = 1'b1;
        end
    end

endmodule : csr_trap_ctrl_mstatus_upd
`default_nettype wire

// File: rtl/csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : csr_trap_ctrl
// Description : Trap/return sequencer and CSR write-port arbiter between the
//               writeback stage and a single-write-port CSR file.
//               Exception : mepc, mcause, mstatus written on consecutive
//                           cycles, then a redirect to the mtvec base.
//               mret      : mstatus restored, then a redirect to mepc.
//               Idle      : writeback CSR writes forwarded combinationally.
// Ports       : clock/reset            clock, synchronous active-high reset
//               wb_csr_*_i             writeback CSR write request
//               excp_flush_i/mret_flush_i  sequence triggers
//               excp_mcause_i/excp_mepc_i  trap information
//               mtvec/mepc/mstatus_rd_i    live CSR read values
//               csr_*_o                CSR file write port
//               redirect_*_o           one-cycle fetch redirect
//               busy_o                 sequence in progress
//               wr_drop_o              sticky: writeback write dropped
// Revision    : 1.0  initial release
// ============================================================================
module csr_trap_ctrl
    import csr_trap_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_csr_we_i,
    input  logic [11:0] wb_csr_addr_i,
    input  logic [31:0] wb_csr_wdata_i,
    input  logic        excp_flush_i,
    input  logic        mret_flush_i,
    input  logic [31:0] excp_mcause_i,
    input  logic [31:0] excp_mepc_i,
    input  logic [31:0] mtvec_rd_i,
    input  logic [31:0] mepc_rd_i,
    input  logic [31:0] mstatus_rd_i,
    output logic        csr_we_o,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_wdata_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        busy_o,
    output logic        wr_drop_o
);

    state_e      r_state;
    state_e      w_next_state;
    kind_e       r_kind;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic        r_wr_drop;

    logic        w_idle;
    logic [31:0] w_mstatus_next;
    kind_e       w_upd_kind;

    logic        w_we;
    logic [11:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_redir_valid;
    logic [31:0] w_redir_pc;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_upd_kind = (r_state == ST_M_STATUS) ? KIND_MRET : KIND_TRAP;

    csr_trap_ctrl_mstatus_upd u_mstatus_upd (
        .mstatus_i (mstatus_rd_i),
        .kind_i    (w_upd_kind),
        .mstatus_o (w_mstatus_next)
    );

    // ------------------------------------------------------------------
    // State register and latched trap information
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_kind    <= KIND_TRAP;
            r_mepc    <= 32'd0;
            r_mcause  <= 32'd0;
            r_wr_drop <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_idle && excp_flush_i) begin
                r_kind   <= KIND_TRAP;
                r_mepc   <= excp_mepc_i & c_PC_MASK;
                r_mcause <= excp_mcause_i;
            end else if (w_idle && mret_flush_i) begin
                r_kind <= KIND_MRET;
            end
            // Writes arriving mid-sequence cannot be serviced; flag them
            if (!w_idle && wb_csr_we_i) begin
                r_wr_drop <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (excp_flush_i) begin
                    w_next_state = ST_T_EPC;
                end else if (mret_flush_i) begin
                    w_next_state = ST_M_STATUS;
                end
            end
            ST_T_EPC:    w_next_state = ST_T_CAUSE;
            ST_T_CAUSE:  w_next_state = ST_T_STATUS;
            ST_T_STATUS: w_next_state = ST_REDIR;
            ST_M_STATUS: w_next_state = ST_REDIR;
            ST_REDIR:    w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_we          = 1'b0;
        w_addr        = 12'd0;
        w_wdata       = 32'd0;
        w_redir_valid = 1'b0;
        w_redir_pc    = 32'd0;
        case (r_state)
            ST_IDLE: begin
                // A write alongside a flush belongs to the flushed
                // instruction and must not commit
                w_we    = wb_csr_we_i & ~excp_flush_i & ~mret_flush_i;
                w_addr  = wb_csr_addr_i;
                w_wdata = wb_csr_wdata_i;
            end
            ST_T_EPC: begin
                w_we    = 1'b1;
                w_addr  = c_CSR_MEPC;
                w_wdata = r_mepc;
            end
            ST_T_CAUSE: begin
                w_we    = 1'b1;
                w_addr  = c_CSR_MCAUSE;
                w_wdata = r_mcause;
            end
            ST_T_STATUS, ST_M_STATUS: begin
                w_we    = 1'b1;
                w_addr  = c_CSR_MSTATUS;
                w_wdata = w_mstatus_next;
            end
            ST_REDIR: begin
                w_redir_valid = 1'b1;
                // Exceptions only: vectored mode still uses the base
                w_redir_pc    = (r_kind == KIND_MRET) ? (mepc_rd_i & c_PC_MASK)
                                                      : (mtvec_rd_i & c_PC_MASK);
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    // While reset is asserted nothing may reach the CSR file or the
    // frontend, even if the state register still holds a sequence state
    assign csr_we_o         = w_we & ~reset;
    assign csr_addr_o       = reset ? 12'd0 : w_addr;
    assign csr_wdata_o      = reset ? 32'd0 : w_wdata;
    assign redirect_valid_o = w_redir_valid & ~reset;
    assign redirect_pc_o    = reset ? 32'd0 : w_redir_pc;
    assign busy_o           = ~w_idle & ~reset;
    assign wr_drop_o        = r_wr_drop & ~reset;

endmodule : csr_trap_ctrl
`default_nettype wire

// File: tb/tb_csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_trap_ctrl
// Description : Self-checking bench for csr_trap_ctrl. A queue of pending
//               sequence actions models the expected CSR writes and
//               redirects cycle by cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_csr_trap_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_csr_we_i;
    logic [11:0] wb_csr_addr_i;
    logic [31:0] wb_csr_wdata_i;
    logic        excp_flush_i;
    logic        mret_flush_i;
    logic [31:0] excp_mcause_i;
    logic [31:0] excp_mepc_i;
    logic [31:0] mtvec_rd_i;
    logic [31:0] mepc_rd_i;
    logic [31:0] mstatus_rd_i;
    logic        csr_we_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        busy_o;
    logic        wr_drop_o;

    always #5 clock = ~clock;

    csr_trap_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .wb_csr_we_i      (wb_csr_we_i),
        .wb_csr_addr_i    (wb_csr_addr_i),
        .wb_csr_wdata_i   (wb_csr_wdata_i),
        .excp_flush_i     (excp_flush_i),
        .mret_flush_i     (mret_flush_i),
        .excp_mcause_i    (excp_mcause_i),
        .excp_mepc_i      (excp_mepc_i),
        .mtvec_rd_i       (mtvec_rd_i),
        .mepc_rd_i        (mepc_rd_i),
        .mstatus_rd_i     (mstatus_rd_i),
        .csr_we_o         (csr_we_o),
        .csr_addr_o       (csr_addr_o),
        .csr_wdata_o      (csr_wdata_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .busy_o           (busy_o),
        .wr_drop_o        (wr_drop_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: list of actions still owed by an accepted sequence
    localparam int A_W_EPC   = 0;
    localparam int A_W_CAUSE = 1;
    localparam int A_W_STRAP = 2;
    localparam int A_W_SMRET = 3;
    localparam int A_R_TVEC  = 4;
    localparam int A_R_EPC   = 5;

    int          act_q[$];
    logic [31:0] m_epc   = 32'd0;
    logic [31:0] m_cause = 32'd0;
    logic        m_drop  = 1'b0;

    function automatic logic [31:0] trap_status(input logic [31:0] m);
        logic [31:0] r;
        r = m & ~32'h0000_1888;
        r = r | ({31'd0, m[3]} << 7) | 32'h0000_1800;
        return r;
    endfunction

    function automatic logic [31:0] mret_status(input logic [31:0] m);
        logic [31:0] r;
        r = m & ~32'h0000_1888;
        r = r | ({31'd0, m[7]} << 3) | 32'h0000_0080 | 32'h0000_1800;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        reset        = 1'b0;
        wb_csr_we_i  = 1'b0;
        excp_flush_i = 1'b0;
        mret_flush_i = 1'b0;
    endtask

    // One cycle: inputs already driven just after the previous rising edge;
    // outputs are checked mid-cycle, then the model advances with the edge.
    task automatic cyc();
        logic        e_we, e_rv, e_busy;
        logic [11:0] e_addr;
        logic [31:0] e_data, e_pc;
        logic        cmp_wr;
        int          a;
        #3;
        e_we = 1'b0; e_addr = 12'd0; e_data = 32'd0;
        e_rv = 1'b0; e_pc = 32'd0; e_busy = 1'b0;
        cmp_wr = 1'b1;
        a = -1;
        if (reset) begin
            chk("rst_we",    {31'd0, csr_we_o},         32'd0);
            chk("rst_addr",  {20'd0, csr_addr_o},       32'd0);
            chk("rst_data",  csr_wdata_o,               32'd0);
            chk("rst_rv",    {31'd0, redirect_valid_o}, 32'd0);
            chk("rst_pc",    redirect_pc_o,             32'd0);
            chk("rst_busy",  {31'd0, busy_o},           32'd0);
            chk("rst_drop",  {31'd0, wr_drop_o},        32'd0);
            act_q.delete();
            m_drop = 1'b0;
        end else begin
            if (act_q.size() > 0) begin
                a      = act_q[0];
                e_busy = 1'b1;
                case (a)
                    A_W_EPC:   begin e_we = 1'b1; e_addr = 12'h341; e_data = m_epc; end
                    A_W_CAUSE: begin e_we = 1'b1; e_addr = 12'h342; e_data = m_cause; end
                    A_W_STRAP: begin e_we = 1'b1; e_addr = 12'h300; e_data = trap_status(mstatus_rd_i); end
                    A_W_SMRET: begin e_we = 1'b1; e_addr = 12'h300; e_data = mret_status(mstatus_rd_i); end
                    A_R_TVEC:  begin e_rv = 1'b1; e_pc = {mtvec_rd_i[31:2], 2'b00}; cmp_wr = 1'b0; end
                    default:   begin e_rv = 1'b1; e_pc = {mepc_rd_i[31:2], 2'b00}; cmp_wr = 1'b0; end
                endcase
            end else begin
                e_addr = wb_csr_addr_i;
                e_data = wb_csr_wdata_i;
                e_we   = wb_csr_we_i && !excp_flush_i && !mret_flush_i;
            end
            chk("we",    {31'd0, csr_we_o},         {31'd0, e_we});
            if (cmp_wr) begin
                chk("addr", {20'd0, csr_addr_o}, {20'd0, e_addr});
                chk("data", csr_wdata_o,         e_data);
            end
            chk("rv",    {31'd0, redirect_valid_o}, {31'd0, e_rv});
            if (e_rv) chk("pc", redirect_pc_o, e_pc);
            chk("busy",  {31'd0, busy_o},           {31'd0, e_busy});
            chk("drop",  {31'd0, wr_drop_o},        {31'd0, m_drop});
            // Advance the model
            if (a >= 0) begin
                void'(act_q.pop_front());
                if (wb_csr_we_i) m_drop = 1'b1;
            end else if (excp_flush_i) begin
                m_epc   = {excp_mepc_i[31:2], 2'b00};
                m_cause = excp_mcause_i;
                act_q   = '{A_W_EPC, A_W_CAUSE, A_W_STRAP, A_R_TVEC};
            end else if (mret_flush_i) begin
                act_q   = '{A_W_SMRET, A_R_EPC};
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        idle_inputs();
        reset          = 1'b1;
        wb_csr_addr_i  = 12'd0;
        wb_csr_wdata_i = 32'd0;
        excp_mcause_i  = 32'd0;
        excp_mepc_i    = 32'd0;
        mtvec_rd_i     = 32'd0;
        mepc_rd_i      = 32'd0;
        mstatus_rd_i   = 32'd0;
        @(posedge clock);
        #1;
        cyc();                                   // reset held: all zero
        idle_inputs();
        cyc();                                   // idle after reset

        // Exception with the reference values
        excp_flush_i  = 1'b1;
        excp_mcause_i = 32'h2;
        excp_mepc_i   = 32'h8000_0104;
        mstatus_rd_i  = 32'h0000_0008;
        mtvec_rd_i    = 32'h8000_0401;
        cyc();
        idle_inputs();
        repeat (4) cyc();
        chk("tp_status", trap_status(32'h0000_0008), 32'h0000_1880);

        // mret with the reference values
        mret_flush_i = 1'b1;
        mstatus_rd_i = 32'h0000_1880;
        mepc_rd_i    = 32'h8000_0108;
        cyc();
        idle_inputs();
        repeat (2) cyc();

        // Pass-through in idle
        wb_csr_we_i    = 1'b1;
        wb_csr_addr_i  = 12'h305;
        wb_csr_wdata_i = 32'h8000_0000;
        cyc();
        idle_inputs();

        // Collision: flush with a write, then a write mid-sequence
        excp_flush_i   = 1'b1;
        wb_csr_we_i    = 1'b1;
        wb_csr_addr_i  = 12'h340;
        wb_csr_wdata_i = 32'h1234_5678;
        excp_mcause_i  = 32'h5;
        excp_mepc_i    = 32'h8000_0203;
        cyc();
        idle_inputs();
        cyc();
        wb_csr_we_i = 1'b1;                      // T+2
        cyc();
        idle_inputs();
        repeat (3) cyc();

        // Reset during a trap at T+2, then a fresh mret
        excp_flush_i = 1'b1;
        cyc();
        idle_inputs();
        cyc();
        reset = 1'b1;
        cyc();
        idle_inputs();
        cyc();
        mret_flush_i = 1'b1;
        mstatus_rd_i = 32'h0000_0080;
        mepc_rd_i    = 32'h8000_0aa7;
        cyc();
        idle_inputs();
        repeat (3) cyc();

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            reset          = ($urandom_range(0, 79) == 0);
            wb_csr_we_i    = ($urandom_range(0, 2) == 0);
            wb_csr_addr_i  = 12'($urandom);
            wb_csr_wdata_i = $urandom;
            excp_flush_i   = ($urandom_range(0, 6) == 0);
            mret_flush_i   = ($urandom_range(0, 8) == 0);
            excp_mcause_i  = $urandom;
            excp_mepc_i    = $urandom;
            mtvec_rd_i     = $urandom;
            mepc_rd_i      = $urandom;
            mstatus_rd_i   = $urandom;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_csr_trap_ctrl
`default_nettype wire
